vcb_mod_updown_counter: RTL and testbench
=========================================

Name: vcb_mod_updown_counter

Overview:
Parametrised, loadable modulo up/down counter with runtime-programmable lower and upper bounds. It also has a wrap or saturate mode, TC/CEO outputs for cascading, and registered status pulses. It is the general-purpose successor to the fixed 1..999 10-bit counter. It is used in display, timer and prescaler chains where the counting range is set by software or by a front panel.

Parameters:
WIDTH, 10, counter and bound width in bits
LO_RST, 1, lower bound loaded on reset (must be <= HI_RST < 2**WIDTH)
HI_RST, 999, upper bound loaded on reset

Ports:
clk  input  1  clock, rising edge
clr  input  1  reset, asynchronous, active-high
ce  input  1  count enable
up  input  1  direction: 1 = up, 0 = down
L  input  1  synchronous load of di
di  input  WIDTH  load value
cfg_we  input  1  write new bounds
cfg_lo  input  WIDTH  new lower bound
cfg_hi  input  WIDTH  new upper bound
sat  input  1  1 = saturate at bound, 0 = wrap
Q  output  WIDTH  count value
TC  output  1  terminal count (combinational)
CEO  output  1  cascade enable out (combinational)
wrap  output  1  registered pulse: a wrap occurred on the previous edge
clamped  output  1  registered pulse: the previous load was clamped
cfg_err  output  1  registered pulse: the previous cfg_we was rejected

Behaviour:
Reset:
- clr high asynchronously sets lo_r = LO_RST, hi_r = HI_RST, Q = LO_RST, wrap = clamped = cfg_err = 0.
- clr dominates every other input, including in the middle of a count or load.

Register state:
- lo_r and hi_r are internal bound registers.
- Invariant: lo_r <= Q <= hi_r at all times after reset.

Update priority on each rising clk edge (clr low), highest first:
1. cfg_we:
   - If cfg_lo <= cfg_hi: lo_r <= cfg_lo, hi_r <= cfg_hi, Q <= cfg_lo.
   - Otherwise: bounds and Q are unchanged and cfg_err pulses for 1 cycle.
   - L and ce are ignored in this cycle.
2. L:
   - Q <= clamp(di, lo_r, hi_r).
   - clamped pulses if di < lo_r or di > hi_r.
   - ce is ignored in this cycle.
3. ce & up:
   - If Q == hi_r: Q <= sat ? Q : lo_r. When sat = 0, wrap pulses.
   - Else: Q <= Q + 1.
4. ce & ~up:
   - If Q == lo_r: Q <= sat ? Q : hi_r. When sat = 0, wrap pulses.
   - Else: Q <= Q - 1.
5. Otherwise Q holds.

Outputs and timing:
- wrap, clamped and cfg_err are registered, 1-cycle pulses. Each deasserts on the next edge unless it is re-triggered.
- TC = up ? (Q == hi_r) : (Q == lo_r). It is evaluated on the current Q and the current up, with no latency.
- CEO = ce & TC & ~sat. It is never asserted in saturate mode, so downstream stages do not advance.
- Degenerate range lo_r == hi_r: TC is always 1. The count holds its value. When sat = 0, CEO = ce and wrap pulses on every enabled edge.
- Direction may change on any cycle. The next step uses the new direction, with no extra latency.
- Arithmetic: unsigned WIDTH bits. Q + 1 and Q - 1 never overflow because of the bound checks.
- Comparisons are unsigned.

Test Plan:
- Reset and up-wrap: release clr with defaults, ce = 1, up = 1 -> Q counts 1, 2, …, 999. TC = CEO = 1 at 999. Next edge Q = 1 and wrap = 1 for one cycle.
- Down-wrap and direction change: L with di = 3, then up = 0, ce = 1 -> Q goes 3, 2, 1 (TC = 1 at Q = 1), then 999. Set up = 1 at Q = 998 -> next value is 999.
- Saturate: sat = 1, bounds 10..20, Q = 20, up = 1, ce = 1 for 5 edges -> Q stays 20, TC = 1, CEO = 0, wrap never asserted.
- Bounds config: cfg_we with lo = 5, hi = 9 -> Q = 5. Then cfg_we with lo = 12, hi = 7 -> cfg_err pulse, bounds and Q unchanged. Then cfg_we together with L in the same cycle -> cfg_we wins.
- Load clamp: bounds 5..9, L with di = 2 -> Q = 5, clamped = 1. L with di = 15 -> Q = 9, clamped = 1. L with di = 7 -> Q = 7, clamped = 0. L together with ce -> ce ignored.
- Async reset mid-count: assert clr between clock edges while Q = 500 -> Q = 1 and bounds = 1..999 immediately, without waiting for clk. Deassert clr -> counting resumes from 1. Also check lo == hi = 4 with sat = 0: Q stays 4, and TC, CEO and wrap are high every enabled cycle.

Source files
------------

// File: rtl/vcb_mod_updown_counter.sv
// -----------------------------------------------------------------------------
// vcb_mod_updown_counter
//
// Loadable modulo up/down counter. Its lower and upper bounds can be changed at
// runtime. At a bound the counter either wraps or saturates. TC and CEO are
// provided for cascading. Three registered one-cycle status pulses are also
// provided.
//
// Parameters
//   WIDTH   counter and bound width in bits
//   LO_RST  lower bound loaded on reset (LO_RST <= HI_RST < 2**WIDTH)
//   HI_RST  upper bound loaded on reset
//
// Ports
//   clk      in   rising-edge clock
//   clr      in   asynchronous active-high reset
//   ce       in   count enable
//   up       in   direction (1 = up, 0 = down)
//   L        in   synchronous load of di (clamped into the current bounds)
//   di       in   load value
//   cfg_we   in   write new bounds (rejected when cfg_lo > cfg_hi)
//   cfg_lo   in   new lower bound
//   cfg_hi   in   new upper bound
//   sat      in   1 = saturate at the bound, 0 = wrap
//   Q        out  count value (registered)
//   TC       out  terminal count for the current direction (combinational)
//   CEO      out  cascade enable out = ce & TC & ~sat (combinational)
//   wrap     out  registered pulse: a wrap happened on the previous edge
//   clamped  out  registered pulse: the previous load was clamped
//   cfg_err  out  registered pulse: the previous bounds write was rejected
// -----------------------------------------------------------------------------
module vcb_mod_updown_counter #(
    parameter int WIDTH  = 10,
    parameter int LO_RST = 1,
    parameter int HI_RST = 999
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ce,
    input  logic             up,
    input  logic             L,
    input  logic [WIDTH-1:0] di,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_lo,
    input  logic [WIDTH-1:0] cfg_hi,
    input  logic             sat,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             CEO,
    output logic             wrap,
    output logic             clamped,
    output logic             cfg_err
);

    localparam logic [WIDTH-1:0] LO_RST_C = LO_RST[WIDTH-1:0];
    localparam logic [WIDTH-1:0] HI_RST_C = HI_RST[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_C    = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_r;
    logic             wrap_r;
    logic             clamped_r;
    logic             cfg_err_r;

    logic [WIDTH-1:0] q_nxt_s;
    logic [WIDTH-1:0] lo_nxt_s;
    logic [WIDTH-1:0] hi_nxt_s;
    logic             wrap_nxt_s;
    logic             clamped_nxt_s;
    logic             cfg_err_nxt_s;
    logic             at_hi_s;
    logic             at_lo_s;
    logic             tc_s;

    // Clamp a load value into [lo, hi]. The caller guarantees lo <= hi.
    function automatic logic [WIDTH-1:0] clamp_f(
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi
    );
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end else begin
            return v;
        end
    endfunction

    assign at_hi_s = (q_r == hi_r);
    assign at_lo_s = (q_r == lo_r);

    // Terminal count and cascade enable, taken from the current Q and direction.
    always_comb begin
        tc_s = 1'b0;
        if (up) begin
            tc_s = at_hi_s;
        end else begin
            tc_s = at_lo_s;
        end
    end

    assign TC      = tc_s;
    assign CEO     = ce & tc_s & ~sat;
    assign Q       = q_r;
    assign wrap    = wrap_r;
    assign clamped = clamped_r;
    assign cfg_err = cfg_err_r;

    // Next-state selection, highest priority first: bounds write, load, count.
    always_comb begin
        q_nxt_s       = q_r;
        lo_nxt_s      = lo_r;
        hi_nxt_s      = hi_r;
        wrap_nxt_s    = 1'b0;
        clamped_nxt_s = 1'b0;
        cfg_err_nxt_s = 1'b0;
        if (cfg_we) begin
            if (cfg_lo <= cfg_hi) begin
                lo_nxt_s = cfg_lo;
                hi_nxt_s = cfg_hi;
                q_nxt_s  = cfg_lo;
            end else begin
                // Reject an inverted range so the lo <= Q <= hi invariant holds.
                cfg_err_nxt_s = 1'b1;
            end
        end else if (L) begin
            q_nxt_s       = clamp_f(di, lo_r, hi_r);
            clamped_nxt_s = (di < lo_r) || (di > hi_r);
        end else if (ce) begin
            if (up) begin
                if (at_hi_s) begin
                    if (sat) begin
                        q_nxt_s = q_r;
                    end else begin
                        q_nxt_s    = lo_r;
                        wrap_nxt_s = 1'b1;
                    end
                end else begin
                    q_nxt_s = q_r + ONE_C;
                end
            end else begin
                if (at_lo_s) begin
                    if (sat) begin
                        q_nxt_s = q_r;
                    end else begin
                        q_nxt_s    = hi_r;
                        wrap_nxt_s = 1'b1;
                    end
                end else begin
                    q_nxt_s = q_r - ONE_C;
                end
            end
        end else begin
            q_nxt_s = q_r;
        end
    end

    // State and status registers, with asynchronous clear to the reset bounds.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_r       <= LO_RST_C;
            lo_r      <= LO_RST_C;
            hi_r      <= HI_RST_C;
            wrap_r    <= 1'b0;
            clamped_r <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            q_r       <= q_nxt_s;
            lo_r      <= lo_nxt_s;
            hi_r      <= hi_nxt_s;
            wrap_r    <= wrap_nxt_s;
            clamped_r <= clamped_nxt_s;
            cfg_err_r <= cfg_err_nxt_s;
        end
    end

endmodule

// File: tb/tb_vcb_mod_updown_counter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for vcb_mod_updown_counter. A behavioural model built on
// offsets within the range and modular arithmetic predicts every output.
// -----------------------------------------------------------------------------
module tb_vcb_mod_updown_counter;

    localparam int W = 10;

    logic          clk = 1'b0;
    logic          clr, ce, up, L, cfg_we, sat;
    logic [W-1:0]  di, cfg_lo, cfg_hi;
    logic [W-1:0]  q_s;
    logic          tc_s, ceo_s, wrap_s, clamped_s, cfg_err_s;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    int m_lo, m_hi, m_q;
    bit m_wrap, m_clamped, m_err;

    vcb_mod_updown_counter #(.WIDTH(W), .LO_RST(1), .HI_RST(999)) dut (
        .clk(clk), .clr(clr), .ce(ce), .up(up), .L(L), .di(di),
        .cfg_we(cfg_we), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .sat(sat),
        .Q(q_s), .TC(tc_s), .CEO(ceo_s), .wrap(wrap_s),
        .clamped(clamped_s), .cfg_err(cfg_err_s)
    );

    always #5 clk = ~clk;

    wire [W+4:0] dut_vec = {q_s, tc_s, ceo_s, wrap_s, clamped_s, cfg_err_s};

    task automatic model_reset();
        m_lo = 1; m_hi = 999; m_q = 1;
        m_wrap = 1'b0; m_clamped = 1'b0; m_err = 1'b0;
    endtask

    // Model one rising edge from the inputs that are applied now.
    task automatic model_edge();
        int range, pos;
        m_wrap = 1'b0; m_clamped = 1'b0; m_err = 1'b0;
        if (cfg_we) begin
            if (int'(cfg_lo) <= int'(cfg_hi)) begin
                m_lo = cfg_lo; m_hi = cfg_hi; m_q = cfg_lo;
            end else begin
                m_err = 1'b1;
            end
        end else if (L) begin
            m_clamped = (int'(di) < m_lo) || (int'(di) > m_hi);
            m_q = (int'(di) < m_lo) ? m_lo : ((int'(di) > m_hi) ? m_hi : int'(di));
        end else if (ce) begin
            range = m_hi - m_lo + 1;
            pos   = m_q - m_lo;
            if (sat) begin
                m_q = up ? ((m_q + 1 > m_hi) ? m_hi : m_q + 1)
                         : ((m_q - 1 < m_lo) ? m_lo : m_q - 1);
            end else begin
                m_wrap = up ? (pos == range - 1) : (pos == 0);
                m_q = m_lo + (up ? (pos + 1) % range : (pos - 1 + range) % range);
            end
        end
    endtask

    function automatic logic [W+4:0] exp_vec();
        logic [W-1:0] mq;
        logic tc;
        mq = m_q[W-1:0];
        tc = up ? (m_q == m_hi) : (m_q == m_lo);
        return {mq, tc, ce & tc & ~sat, m_wrap, m_clamped, m_err};
    endfunction

    // One clock edge: the model follows the edge and outputs settle 1 ns later.
    task automatic step();
        @(posedge clk);
        if (clr) model_reset(); else model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        ce = 1'b0; up = 1'b1; L = 1'b0; cfg_we = 1'b0; sat = 1'b0;
        di = '0; cfg_lo = '0; cfg_hi = '0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        idle_inputs();
        #3;
        model_reset();
        tests_run++;
        if (dut_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL reset: got %h expected %h", dut_vec, exp_vec());
        end
        tests_run++;
        if (q_s !== 10'd1) begin
            tests_failed++;
            $display("FAIL reset_q: got %0d expected 1", q_s);
        end
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_up_wrap();
        ce = 1'b1; up = 1'b1;
        for (int i = 0; i < 999; i++) begin
            step();
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL up_wrap step %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            if (i == 997) begin
                tests_run++;
                if ({q_s, tc_s, ceo_s} !== {10'd999, 1'b1, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL up_top: got Q=%0d TC=%b CEO=%b expected 999 1 1", q_s, tc_s, ceo_s);
                end
            end
        end
        tests_run++;
        if ({q_s, wrap_s} !== {10'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL up_wrap_edge: got Q=%0d wrap=%b expected 1 1", q_s, wrap_s);
        end
        step();
        tests_run++;
        if (wrap_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_pulse_len: got %b expected 0", wrap_s);
        end
    endtask

    task automatic test_down_wrap();
        logic [W-1:0] want [4] = '{10'd2, 10'd1, 10'd999, 10'd998};
        ce = 1'b0; L = 1'b1; di = 10'd3;
        step();
        L = 1'b0; ce = 1'b1; up = 1'b0;
        tests_run++;
        if (q_s !== 10'd3) begin
            tests_failed++;
            $display("FAIL load3: got %0d expected 3", q_s);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (dut_vec !== exp_vec() || q_s !== want[i]) begin
                tests_failed++;
                $display("FAIL down_wrap step %0d: got %h (Q=%0d) expected %h (Q=%0d)",
                         i, dut_vec, q_s, exp_vec(), want[i]);
            end
        end
        up = 1'b1;
        step();
        tests_run++;
        if (q_s !== 10'd999 || dut_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL dir_change: got Q=%0d expected 999", q_s);
        end
    endtask

    task automatic test_saturate();
        ce = 1'b0; cfg_we = 1'b1; cfg_lo = 10'd10; cfg_hi = 10'd20;
        step();
        cfg_we = 1'b0; L = 1'b1; di = 10'd20;
        step();
        L = 1'b0; sat = 1'b1; ce = 1'b1; up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if ({q_s, tc_s, ceo_s, wrap_s} !== {10'd20, 1'b1, 1'b0, 1'b0} || dut_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL saturate step %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        sat = 1'b0; ce = 1'b0;
    endtask

    task automatic test_cfg();
        cfg_we = 1'b1; cfg_lo = 10'd5; cfg_hi = 10'd9;
        step();
        tests_run++;
        if (q_s !== 10'd5 || dut_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL cfg_ok: got Q=%0d expected 5", q_s);
        end
        cfg_lo = 10'd12; cfg_hi = 10'd7;
        step();
        tests_run++;
        if ({q_s, cfg_err_s} !== {10'd5, 1'b1} || dut_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL cfg_err: got Q=%0d err=%b expected 5 1", q_s, cfg_err_s);
        end
        cfg_lo = 10'd6; cfg_hi = 10'd9; L = 1'b1; di = 10'd8; ce = 1'b1;
        step();
        tests_run++;
        if ({q_s, cfg_err_s} !== {10'd6, 1'b0} || dut_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL cfg_over_load: got Q=%0d err=%b expected 6 0", q_s, cfg_err_s);
        end
        cfg_we = 1'b0; L = 1'b0; ce = 1'b0;
        cfg_we = 1'b1; cfg_lo = 10'd5; cfg_hi = 10'd9;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_clamp();
        logic [W-1:0] dis [4] = '{10'd2, 10'd15, 10'd7, 10'd6};
        logic [W-1:0] qs  [4] = '{10'd5, 10'd9, 10'd7, 10'd6};
        logic         cls [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            L = 1'b1; di = dis[i]; ce = (i == 3); up = 1'b1;
            step();
            tests_run++;
            if ({q_s, clamped_s} !== {qs[i], cls[i]} || dut_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL clamp %0d: got Q=%0d clamped=%b expected %0d %b",
                         i, q_s, clamped_s, qs[i], cls[i]);
            end
        end
        L = 1'b0; ce = 1'b0;
    endtask

    task automatic test_async_reset();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_reset();
        ce = 1'b1; up = 1'b1; sat = 1'b0;
        for (int i = 0; i < 499; i++) step();
        tests_run++;
        if (q_s !== 10'd500 || dut_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL pre_clr: got Q=%0d expected 500", q_s);
        end
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        tests_run++;
        if (q_s !== 10'd1 || dut_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL async_clr: got Q=%0d expected 1", q_s);
        end
        @(negedge clk);
        clr = 1'b0;
        step();
        tests_run++;
        if (q_s !== 10'd2 || dut_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL resume: got Q=%0d expected 2", q_s);
        end
    endtask

    task automatic test_degenerate();
        ce = 1'b0; cfg_we = 1'b1; cfg_lo = 10'd4; cfg_hi = 10'd4;
        step();
        cfg_we = 1'b0; ce = 1'b1; sat = 1'b0;
        for (int i = 0; i < 6; i++) begin
            up = i[0];
            step();
            tests_run++;
            if ({q_s, tc_s, ceo_s, wrap_s} !== {10'd4, 1'b1, 1'b1, 1'b1} || dut_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL degenerate %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int lo, hi, t;
        for (int i = 0; i < 400; i++) begin
            cfg_we = ($urandom_range(0, 19) == 0);
            lo = $urandom_range(0, 1010);
            hi = lo + $urandom_range(0, 12);
            if ($urandom_range(0, 4) == 0) begin
                t = lo; lo = hi; hi = t;
            end
            cfg_lo = lo[W-1:0]; cfg_hi = hi[W-1:0];
            L   = ($urandom_range(0, 9) == 0);
            di  = W'($urandom_range(0, 1023));
            ce  = ($urandom_range(0, 3) != 0);
            up  = $urandom_range(0, 1) == 1;
            sat = ($urandom_range(0, 3) == 0);
            step();
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_cfg();
        test_clamp();
        test_async_reset();
        test_degenerate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
